snn_tdm_layer: RTL

- Parametrised, time-multiplexed leaky integrate-and-fire (LIF) spiking layer; successor to the fully parallel per-neuron LIF array.
- A single shared update datapath serially sweeps all NEURONS membrane potentials, one neuron per clock, for each accepted input spike vector.
- Adds valid/ready handshakes on input and output spike vectors, saturating signed membranes, a runtime-selectable reset mode, and a byte-wide config port.
- Sits between the input spike register and the next layer or output pins; layers cascade by connecting out_* to the next layer's in_*.

---
 rtl/snn_tdm_layer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/snn_tdm_layer.sv
// Time-multiplexed leaky integrate-and-fire layer: one shared update datapath
// sweeps every neuron's membrane once per accepted input spike vector.
module snn_tdm_layer #(
    parameter int INPUTS    = 16,
    parameter int NEURONS   = 16,
    parameter int MEM_BITS  = 8,
    parameter int STEP_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INPUTS-1:0]    in_spikes,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEURONS-1:0]   out_spikes,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_sel,
    input  logic [7:0]           cfg_data,
    output logic                 busy,
    output logic [STEP_BITS-1:0] step_count
);
    localparam int WEIGHTS   = INPUTS * NEURONS;
    localparam int IDX_BITS  = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int CNT_BITS  = $clog2(INPUTS + 1);
    localparam int WIDE_BITS = MEM_BITS + CNT_BITS + 2;
    localparam int THR_BITS  = MEM_BITS - 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NEURONS - 1);
    localparam logic signed [WIDE_BITS-1:0] MEM_MAX = WIDE_BITS'((1 << (MEM_BITS - 1)) - 1);
    localparam logic signed [WIDE_BITS-1:0] MEM_MIN = ~MEM_MAX;

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

    state_t                 state_reg;
    logic [IDX_BITS-1:0]    idx_reg;
    logic [INPUTS-1:0]      in_reg;
    logic [NEURONS-1:0]     spike_acc_reg;
    logic [NEURONS-1:0]     out_spikes_reg;
    logic                   out_valid_reg;
    logic [STEP_BITS-1:0]   step_reg;
    logic [WEIGHTS-1:0]     weights_reg;
    logic [THR_BITS-1:0]    thr_reg;
    logic [2:0]             shift_reg;
    logic                   mode_reg;

    logic [INPUTS-1:0]          weight_row [NEURONS];
    logic signed [MEM_BITS-1:0] mem_q [NEURONS];

    logic                       mem_clear;
    logic signed [MEM_BITS-1:0] u_cur;
    logic signed [MEM_BITS-1:0] leak;
    logic signed [MEM_BITS-1:0] u_next;
    logic [CNT_BITS-1:0]        pos_cnt;
    logic [CNT_BITS-1:0]        tot_cnt;
    logic signed [WIDE_BITS-1:0] sum_w;
    logic signed [WIDE_BITS-1:0] v_wide;
    logic signed [WIDE_BITS-1:0] v_sat;
    logic signed [WIDE_BITS-1:0] thr_w;
    logic signed [WIDE_BITS-1:0] res_w;
    logic                       fire;
    logic [NEURONS-1:0]         spike_next;

    assign in_ready   = (state_reg == IDLE);
    assign cfg_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign out_valid  = out_valid_reg;
    assign out_spikes = out_spikes_reg;
    assign step_count = step_reg;

    // A clear command wipes membranes in the same cycle the byte is taken.
    assign mem_clear = (state_reg == IDLE) && cfg_valid && (cfg_sel == 2'd3) && cfg_data[7];

    for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
        logic signed [MEM_BITS-1:0] u_reg;

        assign weight_row[gi] = weights_reg[gi*INPUTS +: INPUTS];
        assign mem_q[gi]      = u_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                u_reg <= '0;
            end else if (mem_clear) begin
                u_reg <= '0;
            end else if (state_reg == COMPUTE && idx_reg == IDX_BITS'(gi)) begin
                u_reg <= u_next;
            end
        end
    end

    function automatic logic [CNT_BITS-1:0] popcount(input logic [INPUTS-1:0] bits);
        logic [CNT_BITS-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < INPUTS; i++) begin
            cnt = cnt + CNT_BITS'(bits[i]);
        end
        return cnt;
    endfunction

    assign u_cur = mem_q[idx_reg];

    always_comb begin
        pos_cnt = popcount(in_reg & weight_row[idx_reg]);
        tot_cnt = popcount(in_reg);
        // Matching synapses add +1, mismatching ones -1: 2*pos - total.
        sum_w = $signed({{(WIDE_BITS-CNT_BITS-1){1'b0}}, pos_cnt, 1'b0})
              - $signed({{(WIDE_BITS-CNT_BITS){1'b0}}, tot_cnt});
        if (shift_reg == 3'd0) begin
            leak = '0;
        end else begin
            leak = u_cur >>> shift_reg;
        end
        v_wide = $signed({{(WIDE_BITS-MEM_BITS){u_cur[MEM_BITS-1]}}, u_cur})
               - $signed({{(WIDE_BITS-MEM_BITS){leak[MEM_BITS-1]}}, leak})
               + sum_w;
        if (v_wide > MEM_MAX) begin
            v_sat = MEM_MAX;
        end else if (v_wide < MEM_MIN) begin
            v_sat = MEM_MIN;
        end else begin
            v_sat = v_wide;
        end
        thr_w = $signed({{(WIDE_BITS-THR_BITS){1'b0}}, thr_reg});
        fire  = (v_sat >= thr_w);
        if (!fire) begin
            res_w = v_sat;
        end else if (mode_reg) begin
            res_w = '0;
        end else begin
            res_w = v_sat - thr_w;
        end
        u_next = res_w[MEM_BITS-1:0];
        spike_next = spike_acc_reg;
        spike_next[idx_reg] = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            in_reg         <= '0;
            spike_acc_reg  <= '0;
            out_spikes_reg <= '0;
            out_valid_reg  <= 1'b0;
            step_reg       <= '0;
            weights_reg    <= '1;
            thr_reg        <= THR_BITS'(4);
            shift_reg      <= 3'd4;
            mode_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_valid) begin
                        case (cfg_sel)
                            2'd0: weights_reg <= {cfg_data, weights_reg[WEIGHTS-1:8]};
                            2'd1: thr_reg     <= cfg_data[THR_BITS-1:0];
                            2'd2: shift_reg   <= cfg_data[2:0];
                            default: begin
                                mode_reg <= cfg_data[0];
                                if (cfg_data[7]) begin
                                    step_reg <= '0;
                                end
                            end
                        endcase
                    end
                    if (in_valid) begin
                        in_reg        <= in_spikes;
                        idx_reg       <= '0;
                        spike_acc_reg <= '0;
                        state_reg     <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    spike_acc_reg <= spike_next;
                    if (idx_reg == LAST_IDX) begin
                        out_spikes_reg <= spike_next;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= OUTPUT;
                    end else begin
                        idx_reg <= idx_reg + IDX_BITS'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        step_reg      <= step_reg + STEP_BITS'(1);
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
